// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source 2-deep result FIFOs, round-robin grant,
// registered broadcast to ROB / reservation stations / PC. Flush drops all buffered results.
module cdb_arbiter #(
  parameter int N_SRC  = 3,
  parameter int LOCK_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [N_SRC-1:0]          src_valid,
  output logic [N_SRC-1:0]          src_ready,
  input  logic [N_SRC*LOCK_W-1:0]   src_index,
  input  logic [N_SRC*DATA_W-1:0]   src_result,
  output logic                      cdb_valid,
  output logic [LOCK_W-1:0]         cdb_index,
  output logic [DATA_W-1:0]         cdb_result,
  output logic [1:0]                cdb_src
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RR_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]  push;
  logic [N_SRC-1:0]  pop;
  logic [N_SRC-1:0]  nonempty;
  logic [LOCK_W-1:0] head_index  [N_SRC];
  logic [DATA_W-1:0] head_result [N_SRC];

  logic [RR_W-1:0]   rr_ptr_reg;
  logic              grant_found;
  logic              grant;
  logic [RR_W-1:0]   grant_id;
  logic [LOCK_W-1:0] grant_index;
  logic [DATA_W-1:0] grant_result;

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      logic [PTR_W-1:0]  wr_ptr_reg;
      logic [PTR_W-1:0]  rd_ptr_reg;
      logic [CNT_W-1:0]  count_reg;
      logic [LOCK_W-1:0] idx_mem [DEPTH];
      logic [DATA_W-1:0] res_mem [DEPTH];

      // Ready looks only at the stored count, so a full buffer stalls even when popped.
      assign src_ready[gi]   = (count_reg < CNT_W'(DEPTH));
      assign nonempty[gi]    = (count_reg != '0);
      assign push[gi]        = src_valid[gi] && src_ready[gi] && !flush;
      assign pop[gi]         = grant && (grant_id == RR_W'(gi));
      assign head_index[gi]  = idx_mem[rd_ptr_reg];
      assign head_result[gi] = res_mem[rd_ptr_reg];

      always_ff @(posedge clk) begin
        if (push[gi]) begin
          idx_mem[wr_ptr_reg] <= src_index[gi*LOCK_W +: LOCK_W];
          res_mem[wr_ptr_reg] <= src_result[gi*DATA_W +: DATA_W];
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else if (flush) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push[gi]) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
          if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
          case ({push[gi], pop[gi]})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
          endcase
        end
      end
    end
  endgenerate

  // First non-empty buffer at or after rr_ptr, wrapping modulo N_SRC.
  always_comb begin
    int j;
    j            = 0;
    grant_found  = 1'b0;
    grant_id     = '0;
    grant_index  = '0;
    grant_result = '0;
    for (int k = 0; k < N_SRC; k++) begin
      j = (int'(rr_ptr_reg) + k) % N_SRC;
      if (!grant_found && nonempty[j]) begin
        grant_found  = 1'b1;
        grant_id     = RR_W'(j);
        grant_index  = head_index[j];
        grant_result = head_result[j];
      end
    end
    grant = grant_found && !flush;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_reg <= '0;
      cdb_valid  <= 1'b0;
      cdb_index  <= '0;
      cdb_result <= '0;
      cdb_src    <= '0;
    end else begin
      cdb_valid <= grant;
      if (grant) begin
        cdb_index  <= grant_index;
        cdb_result <= grant_result;
        cdb_src    <= 2'(grant_id);
        rr_ptr_reg <= (grant_id == RR_W'(N_SRC - 1)) ? '0 : grant_id + RR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-based reference model predicts each
// cycle's broadcast and ready vector from the driven stimulus.
module tb_cdb_arbiter;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [2:0]  src_valid;
  logic [2:0]  src_ready;
  logic [14:0] src_index;
  logic [95:0] src_result;
  logic        cdb_valid;
  logic [4:0]  cdb_index;
  logic [31:0] cdb_result;
  logic [1:0]  cdb_src;

  cdb_arbiter #(.N_SRC(3), .LOCK_W(5), .DATA_W(32), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_index  (src_index),
    .src_result (src_result),
    .cdb_valid  (cdb_valid),
    .cdb_index  (cdb_index),
    .cdb_result (cdb_result),
    .cdb_src    (cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [1:0]  s;
    logic [4:0]  idx;
    logic [31:0] res;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  // reference model state
  int          m_cnt [3];
  logic [4:0]  m_idx [3][2];
  logic [31:0] m_res [3][2];
  int          m_rr;
  logic [1:0]  m_lsrc;
  logic [4:0]  m_lidx;
  logic [31:0] m_lres;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, ncyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_rr   = 0;
    m_lsrc = '0;
    m_lidx = '0;
    m_lres = '0;
  endtask

  task automatic cyc(input logic [2:0] v, input logic [14:0] ix, input logic [95:0] rs,
                     input logic fl);
    exp_t       e;
    int         g;
    logic [2:0] rdy;
    src_valid  = v;
    src_index  = ix;
    src_result = rs;
    flush      = fl;
    #1;
    for (int i = 0; i < 3; i++) rdy[i] = (m_cnt[i] < 2);
    check("src_ready", 64'(src_ready), 64'(rdy));
    g = -1;
    if (!fl)
      for (int k = 0; k < 3; k++)
        if (g < 0 && m_cnt[(m_rr + k) % 3] > 0) g = (m_rr + k) % 3;
    if (g >= 0) begin
      m_lsrc = 2'(g);
      m_lidx = m_idx[g][0];
      m_lres = m_res[g][0];
    end
    e.v   = (g >= 0);
    e.s   = m_lsrc;
    e.idx = m_lidx;
    e.res = m_lres;
    exp_q.push_back(e);
    if (fl) begin
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    end else begin
      if (g >= 0) begin
        m_idx[g][0] = m_idx[g][1];
        m_res[g][0] = m_res[g][1];
        m_cnt[g]--;
        m_rr = (g + 1) % 3;
      end
      for (int i = 0; i < 3; i++)
        if (v[i] && rdy[i]) begin
          m_idx[i][m_cnt[i]] = ix[i*5 +: 5];
          m_res[i][m_cnt[i]] = rs[i*32 +: 32];
          m_cnt[i]++;
        end
    end
    @(posedge clk);
    #1;
    ncyc++;
    e = exp_q.pop_front();
    $display("cyc %0d: valid=%0b flush=%0b rdy=%b -> cdb v=%0b src=%0d idx=%0d res=%h",
             ncyc, v, fl, src_ready, cdb_valid, cdb_src, cdb_index, cdb_result);
    check("cdb_valid",  64'(cdb_valid),  64'(e.v));
    check("cdb_src",    64'(cdb_src),    64'(e.s));
    check("cdb_index",  64'(cdb_index),  64'(e.idx));
    check("cdb_result", 64'(cdb_result), 64'(e.res));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(3'b000, 15'd0, 96'd0, 1'b0);
  endtask

  initial begin
    rst        = 1'b0;
    flush      = 1'b0;
    src_valid  = '0;
    src_index  = '0;
    src_result = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid",  64'(cdb_valid),  64'(0));
    check("rst_index",  64'(cdb_index),  64'(0));
    check("rst_result", 64'(cdb_result), 64'(0));
    check("rst_src",    64'(cdb_src),    64'(0));
    check("rst_ready",  64'(src_ready),  64'(3'b111));
    @(negedge clk);
    rst = 1'b1;

    // single ALU push, one-cycle latency
    cyc(3'b001, {5'd0, 5'd0, 5'd5}, {32'd0, 32'd0, 32'h0000_1234}, 1'b0);
    idle(3);

    // all three sources at once
    cyc(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 1'b0);
    idle(4);

    // move rr_ptr to 2 via a load grant, then src0 and src2 contend
    cyc(3'b010, {5'd0, 5'd7, 5'd0}, {32'd0, 32'h77, 32'd0}, 1'b0);
    idle(2);
    cyc(3'b101, {5'd9, 5'd0, 5'd8}, {32'h99, 32'd0, 32'h88}, 1'b0);
    idle(3);

    // ALU and load push every cycle; load backs up
    for (int c = 0; c < 6; c++)
      cyc(3'b011, {5'd0, 5'(20 + c), 5'(10 + c)},
          {32'd0, 32'h2000 + 32'(c), 32'h1000 + 32'(c)}, 1'b0);
    idle(6);

    // fill, then flush with a simultaneous push that must be dropped
    cyc(3'b011, {5'd0, 5'd17, 5'd16}, {32'd0, 32'h17, 32'h16}, 1'b0);
    cyc(3'b011, {5'd0, 5'd19, 5'd18}, {32'd0, 32'h19, 32'h18}, 1'b0);
    cyc(3'b111, {5'd30, 5'd29, 5'd28}, {32'h30, 32'h29, 32'h28}, 1'b1);
    idle(3);

    // async reset mid-stream while a broadcast is live
    cyc(3'b111, {5'd13, 5'd12, 5'd11}, {32'h13, 32'h12, 32'h11}, 1'b0);
    idle(1);
    check("pre_rst_valid", 64'(cdb_valid), 64'(1));
    src_valid = '0;
    #2;
    rst = 1'b0;
    #1;
    check("async_valid",  64'(cdb_valid),  64'(0));
    check("async_index",  64'(cdb_index),  64'(0));
    check("async_result", 64'(cdb_result), 64'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cyc(3'b110, {5'd23, 5'd22, 5'd0}, {32'h23, 32'h22, 32'd0}, 1'b0);
    cyc(3'b001, {5'd0, 5'd0, 5'd21}, {32'd0, 32'd0, 32'h21}, 1'b0);
    idle(4);

    // random traffic with occasional flush
    for (int c = 0; c < 40; c++)
      cyc(3'($urandom_range(0, 7)), 15'($urandom), {$urandom, $urandom, $urandom},
          ($urandom_range(0, 9) == 0));
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
